vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 Parameter V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter CLK_PER_PIX, default 4, system clocks per pixel (100 MHz to 25 MHz).
REQ-006 clk  in  1  system clock; the only clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  reset; synchronous, active-low.
REQ-008 en  in  1  run enable; low freezes all counters and outputs.
REQ-009 x  out  10  current horizontal pixel count, 0..H_TOTAL-1; feeds glyph/paddle/ball renderers.
REQ-010 y  out  10  current line count, 0..V_TOTAL-1.
REQ-011 hsync  out  1  horizontal sync, active-low.
REQ-012 vsync  out  1  vertical sync, active-low.
REQ-013 video_on  out  1  high when x<H_VISIBLE and y<V_VISIBLE.
REQ-014 p_tick  out  1  one-clock pixel strobe.
REQ-015 frame_start  out  1  one-clock pulse when the count wraps to (0,0).

Function
REQ-016 H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
REQ-017 Divider counter div, 0..CLK_PER_PIX-1, increments each clk with en high and wraps to 0; p_tick is high exactly in cycles where div==CLK_PER_PIX-1 and en is high.
REQ-018 x increments on each clk edge where p_tick is high; x==H_TOTAL-1 wraps to 0 and increments y on the same edge.
REQ-019 y==V_TOTAL-1 together with x wrap wraps y to 0; frame_start is high for the single clock following that edge.
REQ-020 Horizontal phase FSM, derived from x: VISIBLE (0..639) -> FRONT (640..655) -> SYNC (656..751) -> BACK (752..799) -> VISIBLE; vertical FSM identical over y: VISIBLE (0..479) -> FRONT (480..489) -> SYNC (490..491) -> BACK (492..524).
REQ-021 hsync is low exactly while the horizontal phase is SYNC; vsync is low exactly while the vertical phase is SYNC.
REQ-022 hsync, vsync, video_on and frame_start are registered from next-count values so they change on the same clk edge as x/y; zero-cycle skew between x/y and the flags.
REQ-023 All counter comparisons are unsigned 10-bit; x and y never exceed H_TOTAL-1 / V_TOTAL-1.
REQ-024 en low: div, x, y and all flags hold; p_tick and frame_start are 0; en re-asserted resumes from the held div value with no skipped or repeated pixel.
REQ-025 Parameters with H_TOTAL or V_TOTAL > 1024, or CLK_PER_PIX < 1, are illegal; an elaboration-time assertion flags them.

Reset
REQ-026 rst_n low at a clk edge sets div=0, x=0, y=0, hsync=1, vsync=1, video_on=0, p_tick=0, frame_start=0, regardless of en.
REQ-027 Reset asserted mid-frame discards the position; the first p_tick after release moves x to 1 and sets video_on=1 (no frame_start for the partial frame).

Structure
REQ-028 Shared package vga_pkg holds the timing defaults (H_*/V_* constants, H_TOTAL, V_TOTAL) and the phase enum {VISIBLE, FRONT, SYNC, BACK}, shared with the renderers and top level.
REQ-029 One sub-module, vga_tick_div, implements the divider and p_tick; the counters and phase logic stay in vga_sync_gen.

Verification
REQ-030 Reset then en=1: p_tick is high every 4th clk; the first p_tick falls on the 4th clk after release; x=1 after it.
REQ-031 Free run one line: hsync low for exactly 384 clks, starting when x becomes 656; line period is 3200 clks; x wraps 799->0 and y increments.
REQ-032 Free run one frame: vsync low for exactly 2 lines (6400 clks) starting when y becomes 490; frame_start pulses once per 1,680,000 clks.
REQ-033 Sample (x,y) = (639,479) -> (640,479): video_on goes 1->0 on the same edge x changes; (799,524) -> (0,0): video_on=1 and frame_start=1 on the same edge.
REQ-034 Drop en for 10 clks at x=300: x, y, div and flags hold and p_tick=0; after re-enable the next x is 301 with the pixel spacing preserved.
REQ-035 Assert rst_n=0 at (400,200) during vsync-inactive: the next edge gives x=0, y=0, hsync=1, vsync=1, video_on=0; the frame then restarts normally.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA 640x480@60 timing defaults and scan phase type.
package vga_pkg;
   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;
   localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   typedef enum logic [1:0] {VISIBLE, FRONT, SYNC, BACK} phase_t;
   // 11-bit compare so a boundary of exactly 1024 still works
   function automatic phase_t phase_of(input logic [9:0] c, input int unsigned vis, input int unsigned front,
                                       input int unsigned sync);
      logic [10:0] v;
      v = {1'b0, c};
      return v < 11'(vis) ? VISIBLE : v < 11'(vis + front) ? FRONT : v < 11'(vis + front + sync) ? SYNC : BACK;
   endfunction
endpackage

// File: rtl/vga_tick_div.sv
// vga_tick_div: divides the system clock down to a one-clock pixel strobe.
module vga_tick_div #(
   parameter int CLK_PER_PIX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic p_tick
);
   localparam int DW = CLK_PER_PIX > 1 ? $clog2(CLK_PER_PIX) : 1;
   logic [DW-1:0] div;
   assign p_tick = en && div == DW'(CLK_PER_PIX - 1);
   always_ff @(posedge clk) begin
      if (!rst_n) div <= '0;
      else if (p_tick) div <= '0;
      else if (en) div <= div + 1'b1;
   end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA scan counters with sync, blanking and frame flags.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_VISIBLE   = vga_pkg::H_VISIBLE,
   parameter int unsigned H_FRONT     = vga_pkg::H_FRONT,
   parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
   parameter int unsigned H_BACK      = vga_pkg::H_BACK,
   parameter int unsigned V_VISIBLE   = vga_pkg::V_VISIBLE,
   parameter int unsigned V_FRONT     = vga_pkg::V_FRONT,
   parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
   parameter int unsigned V_BACK      = vga_pkg::V_BACK,
   parameter int          CLK_PER_PIX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic       frame_start
);
   localparam int unsigned HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   if (HT > 1024 || VT > 1024 || CLK_PER_PIX < 1) begin : g_bad_params
      $error("vga_sync_gen: illegal timing parameters");
   end
   logic [9:0] x_nxt, y_nxt;
   logic       x_wrap, y_wrap;
   phase_t     h_ph, v_ph, h_nxt, v_nxt;
   vga_tick_div #(.CLK_PER_PIX(CLK_PER_PIX)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .p_tick(p_tick)
   );
   always_comb begin
      x_wrap = x == 10'(HT - 1);
      y_wrap = y == 10'(VT - 1);
      x_nxt  = x_wrap ? 10'd0 : x + 10'd1;
      y_nxt  = x_wrap ? (y_wrap ? 10'd0 : y + 10'd1) : y;
      h_nxt  = phase_of(x_nxt, H_VISIBLE, H_FRONT, H_SYNC);
      v_nxt  = phase_of(y_nxt, V_VISIBLE, V_FRONT, V_SYNC);
   end
   // flags are loaded from the next-count values so they move on the same edge as x/y
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x           <= '0;
         y           <= '0;
         h_ph        <= VISIBLE;
         v_ph        <= VISIBLE;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= p_tick && x_wrap && y_wrap;
         if (p_tick) begin
            x        <= x_nxt;
            y        <= y_nxt;
            h_ph     <= h_nxt;
            v_ph     <= v_nxt;
            video_on <= h_nxt == VISIBLE && v_nxt == VISIBLE;
         end
      end
   end
   assign hsync = h_ph != SYNC;
   assign vsync = v_ph != SYNC;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: table and scoreboard checks of vga_sync_gen on a shrunken timing.
module tb_vga_sync_gen;
   localparam int HV = 16, HF = 2, HS = 4, HB = 3, VV = 6, VF = 1, VS = 2, VB = 2, CPP = 4;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       vid;
      logic       pt;
      logic       fs;
   } obs_t;
   typedef struct {
      logic r;
      logic e;
      int   n;
      int   ex;
      int   ey;
   } vec_t;
   logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
   logic [9:0] x, y;
   logic       hsync, vsync, video_on, p_tick, frame_start;
   int         total = 0, bad = 0, cyc = 0;
   int         md = 0, mx = 0, my = 0;
   logic       mvid = 1'b0, mfs = 1'b0;
   obs_t       sb[$];
   vga_sync_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_PER_PIX(CPP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
      .video_on(video_on), .p_tick(p_tick), .frame_start(frame_start)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask
   // one clock: drive, score the pre-edge outputs against the model, advance the model past the edge
   task automatic step(input logic r, input logic e);
      obs_t exp_o, got_o;
      logic tick;
      @(negedge clk);
      rst_n = r;
      en = e;
      #1;
      exp_o.x   = 10'(mx);
      exp_o.y   = 10'(my);
      exp_o.hs  = !(mx >= HV + HF && mx < HV + HF + HS);
      exp_o.vs  = !(my >= VV + VF && my < VV + VF + VS);
      exp_o.vid = mvid;
      exp_o.pt  = e && md == CPP - 1;
      exp_o.fs  = mfs;
      sb.push_back(exp_o);
      got_o = {x, y, hsync, vsync, video_on, p_tick, frame_start};
      exp_o = sb.pop_front();
      total++;
      if (got_o !== exp_o) begin
         bad++;
         $display("FAIL scoreboard cyc=%0d got x=%0d y=%0d hs=%b vs=%b vid=%b pt=%b fs=%b want x=%0d y=%0d hs=%b vs=%b vid=%b pt=%b fs=%b",
                  cyc, got_o.x, got_o.y, got_o.hs, got_o.vs, got_o.vid, got_o.pt, got_o.fs,
                  exp_o.x, exp_o.y, exp_o.hs, exp_o.vs, exp_o.vid, exp_o.pt, exp_o.fs);
      end
      if (!r) begin
         md = 0; mx = 0; my = 0; mvid = 1'b0; mfs = 1'b0;
      end else begin
         tick = e && md == CPP - 1;
         mfs = tick && mx == HT - 1 && my == VT - 1;
         if (tick) begin
            md = 0;
            if (mx == HT - 1) begin
               mx = 0;
               my = (my == VT - 1) ? 0 : my + 1;
            end else mx = mx + 1;
            mvid = mx < HV && my < VV;
         end else if (e) md = md + 1;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_xy(input int tx, input int ty);
      for (int i = 0; i < 3000 && !(x == 10'(tx) && y == 10'(ty)); i++) step(1'b1, 1'b1);
      check($sformatf("reach_%0d_%0d", tx, ty), int'(x == 10'(tx) && y == 10'(ty)), 1);
   endtask
   initial begin
      vec_t tbl[10];
      int   n, first_low, lows, fs_cnt, fs_first, fs_second;
      tbl[0] = '{1'b0, 1'b1, 3, 0, 0};
      tbl[1] = '{1'b1, 1'b1, 3, 0, 0};
      tbl[2] = '{1'b1, 1'b1, 1, 1, 0};
      tbl[3] = '{1'b1, 1'b0, 10, 1, 0};
      tbl[4] = '{1'b1, 1'b1, 4, 2, 0};
      tbl[5] = '{1'b1, 1'b1, 92, 0, 1};
      tbl[6] = '{1'b1, 1'b1, 1000, 0, 0};
      tbl[7] = '{1'b1, 1'b1, 320, 5, 3};
      tbl[8] = '{1'b0, 1'b0, 1, 0, 0};
      tbl[9] = '{1'b1, 1'b1, 8, 2, 0};
      repeat (2) @(posedge clk);
      #1;
      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].e);
         check($sformatf("vec%0d_x", i), int'(x), tbl[i].ex);
         check($sformatf("vec%0d_y", i), int'(y), tbl[i].ey);
      end
      step(1'b0, 1'b1);
      lows = 0;
      first_low = -1;
      for (int i = 0; i < 4 * HT; i++) begin
         if (!hsync) begin
            lows++;
            if (first_low < 0) first_low = int'(x);
         end
         step(1'b1, 1'b1);
      end
      check("hsync_low_clks", lows, 4 * HS);
      check("hsync_start_x", first_low, HV + HF);
      check("line_wrap_y", int'(y), 1);
      step(1'b0, 1'b1);
      lows = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
      for (int i = 0; i < 2 * CPP * HT * VT + 100; i++) begin
         if (i < CPP * HT * VT && !vsync) lows++;
         if (frame_start) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = i;
            else if (fs_second < 0) fs_second = i;
         end
         step(1'b1, 1'b1);
      end
      check("vsync_low_clks", lows, CPP * HT * VS);
      check("frame_start_count", fs_cnt, 2);
      check("frame_start_first", fs_first, CPP * HT * VT);
      check("frame_start_period", fs_second - fs_first, CPP * HT * VT);
      wait_xy(HV - 1, VV - 1);
      check("pre_blank_vid", int'(video_on), 1);
      for (int i = 0; i < 3000 && x == 10'(HV - 1); i++) step(1'b1, 1'b1);
      check("blank_x", int'(x), HV);
      check("blank_vid", int'(video_on), 0);
      wait_xy(HT - 1, VT - 1);
      for (int i = 0; i < 3000 && x == 10'(HT - 1); i++) step(1'b1, 1'b1);
      check("wrap_xy", int'({x, y}), 0);
      check("wrap_vid", int'(video_on), 1);
      check("wrap_fs", int'(frame_start), 1);
      wait_xy(7, 0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      check("hold_x", int'(x), 7);
      check("hold_p_tick", int'(p_tick), 0);
      n = 0;
      while (x == 10'd7 && n < 20) begin
         step(1'b1, 1'b1);
         n++;
      end
      check("resume_x", int'(x), 8);
      check("resume_spacing", n, CPP);
      wait_xy(10, 3);
      step(1'b0, 1'b1);
      check("rst_x", int'(x), 0);
      check("rst_y", int'(y), 0);
      check("rst_hsync", int'(hsync), 1);
      check("rst_vsync", int'(vsync), 1);
      check("rst_vid", int'(video_on), 0);
      for (int i = 0; i < CPP; i++) step(1'b1, 1'b1);
      check("restart_x", int'(x), 1);
      check("restart_vid", int'(video_on), 1);
      check("restart_fs", int'(frame_start), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
